// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges the instruction-fetch and data ports onto one
// memory request interface, with one pending slot per port and a response watchdog.
module mem_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imemory_valid,
   input  logic [31:0] imemory_addr,
   output logic [31:0] imemory_rdata,
   output logic        imemory_error,
   output logic        imemory_ready,
   input  logic        dmemory_valid,
   input  logic [31:0] dmemory_addr,
   input  logic [31:0] dmemory_wdata,
   input  logic [3:0]  dmemory_wstrb,
   output logic [31:0] dmemory_rdata,
   output logic        dmemory_error,
   output logic        dmemory_ready,
   output logic        memory_valid,
   output logic        memory_instr,
   output logic [31:0] memory_addr,
   output logic [31:0] memory_wdata,
   output logic [3:0]  memory_wstrb,
   input  logic [31:0] memory_rdata,
   input  logic        memory_error,
   input  logic        memory_ready
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic GRANT_I = 1'b1;
   localparam logic GRANT_D = 1'b0;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t          state_r;
   logic            owner_i_r;
   logic            last_grant_r;
   logic [CW-1:0]   cnt_r;
   logic            ipend_r;
   logic [31:0]     iaddr_r;
   logic            dpend_r;
   logic [31:0]     daddr_r;
   logic [31:0]     dwdata_r;
   logic [3:0]      dwstrb_r;

   logic            timeout_s;
   logic            done_s;
   logic            i_take_s;
   logic            d_take_s;
   logic            grant_i_s;
   logic            grant_d_s;

   // Transaction completion, request acceptance and round-robin grant decision
   always_comb begin
      logic i_cand_v;
      logic d_cand_v;
      logic can_grant_v;
      timeout_s = 1'b0;
      done_s    = 1'b0;
      i_take_s  = 1'b0;
      d_take_s  = 1'b0;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (TIMEOUT > 0) begin
         timeout_s = (cnt_r == TO_LAST);
      end else begin
         timeout_s = 1'b0;
      end
      done_s = (state_r == ST_BUSY) && (memory_ready || timeout_s);
      // A port's slot frees up in the very cycle its response is delivered
      i_take_s = imemory_valid && !ipend_r &&
                 !((state_r == ST_BUSY) && owner_i_r && !done_s);
      d_take_s = dmemory_valid && !dpend_r &&
                 !((state_r == ST_BUSY) && !owner_i_r && !done_s);
      i_cand_v    = ipend_r || i_take_s;
      d_cand_v    = dpend_r || d_take_s;
      can_grant_v = (state_r == ST_IDLE) || done_s;
      if (can_grant_v && i_cand_v && d_cand_v) begin
         if (last_grant_r == GRANT_I) begin
            grant_d_s = 1'b1;
         end else begin
            grant_i_s = 1'b1;
         end
      end else if (can_grant_v && i_cand_v) begin
         grant_i_s = 1'b1;
      end else if (can_grant_v && d_cand_v) begin
         grant_d_s = 1'b1;
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Arbiter state, ownership, round-robin pointer and watchdog counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         owner_i_r    <= 1'b0;
         last_grant_r <= GRANT_I;
         cnt_r        <= '0;
      end else if (grant_i_s || grant_d_s) begin
         state_r      <= ST_BUSY;
         owner_i_r    <= grant_i_s;
         last_grant_r <= grant_i_s ? GRANT_I : GRANT_D;
         cnt_r        <= '0;
      end else if (done_s) begin
         state_r <= ST_IDLE;
      end else if (state_r == ST_BUSY) begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Instruction pending slot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ipend_r <= 1'b0;
         iaddr_r <= 32'h0000_0000;
      end else if (grant_i_s) begin
         ipend_r <= 1'b0;
      end else if (i_take_s) begin
         ipend_r <= 1'b1;
         iaddr_r <= imemory_addr;
      end
   end

   // Data pending slot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dpend_r  <= 1'b0;
         daddr_r  <= 32'h0000_0000;
         dwdata_r <= 32'h0000_0000;
         dwstrb_r <= 4'h0;
      end else if (grant_d_s) begin
         dpend_r <= 1'b0;
      end else if (d_take_s) begin
         dpend_r  <= 1'b1;
         daddr_r  <= dmemory_addr;
         dwdata_r <= dmemory_wdata;
         dwstrb_r <= dmemory_wstrb;
      end
   end

   // Downstream request registers; a request captured this cycle bypasses its slot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         memory_valid <= 1'b0;
         memory_instr <= 1'b0;
         memory_addr  <= 32'h0000_0000;
         memory_wdata <= 32'h0000_0000;
         memory_wstrb <= 4'h0;
      end else if (grant_i_s) begin
         memory_valid <= 1'b1;
         memory_instr <= 1'b1;
         memory_addr  <= ipend_r ? iaddr_r : imemory_addr;
         memory_wdata <= 32'h0000_0000;
         memory_wstrb <= 4'h0;
      end else if (grant_d_s) begin
         memory_valid <= 1'b1;
         memory_instr <= 1'b0;
         memory_addr  <= dpend_r ? daddr_r : dmemory_addr;
         memory_wdata <= dpend_r ? dwdata_r : dmemory_wdata;
         memory_wstrb <= dpend_r ? dwstrb_r : dmemory_wstrb;
      end else begin
         memory_valid <= 1'b0;
      end
   end

   // Response routing to the owning port; a watchdog expiry reports error with zero data
   always_comb begin
      logic [31:0] rdata_v;
      logic        error_v;
      imemory_ready = 1'b0;
      imemory_rdata = 32'h0000_0000;
      imemory_error = 1'b0;
      dmemory_ready = 1'b0;
      dmemory_rdata = 32'h0000_0000;
      dmemory_error = 1'b0;
      if (memory_ready) begin
         rdata_v = memory_rdata;
         error_v = memory_error;
      end else begin
         rdata_v = 32'h0000_0000;
         error_v = 1'b1;
      end
      if (done_s && owner_i_r) begin
         imemory_ready = 1'b1;
         imemory_rdata = rdata_v;
         imemory_error = error_v;
      end else if (done_s) begin
         dmemory_ready = 1'b1;
         dmemory_rdata = rdata_v;
         dmemory_error = error_v;
      end else begin
         imemory_ready = 1'b0;
         dmemory_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: inputs change on the falling edge, outputs
// are checked 1 time unit later.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imemory_valid = 1'b0;
   logic [31:0] imemory_addr = 32'h0;
   logic [31:0] imemory_rdata;
   logic        imemory_error;
   logic        imemory_ready;
   logic        dmemory_valid = 1'b0;
   logic [31:0] dmemory_addr = 32'h0;
   logic [31:0] dmemory_wdata = 32'h0;
   logic [3:0]  dmemory_wstrb = 4'h0;
   logic [31:0] dmemory_rdata;
   logic        dmemory_error;
   logic        dmemory_ready;
   logic        memory_valid;
   logic        memory_instr;
   logic [31:0] memory_addr;
   logic [31:0] memory_wdata;
   logic [3:0]  memory_wstrb;
   logic [31:0] memory_rdata = 32'h0;
   logic        memory_error = 1'b0;
   logic        memory_ready = 1'b0;

   int passed = 0;
   int total  = 0;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .imemory_valid (imemory_valid),
      .imemory_addr  (imemory_addr),
      .imemory_rdata (imemory_rdata),
      .imemory_error (imemory_error),
      .imemory_ready (imemory_ready),
      .dmemory_valid (dmemory_valid),
      .dmemory_addr  (dmemory_addr),
      .dmemory_wdata (dmemory_wdata),
      .dmemory_wstrb (dmemory_wstrb),
      .dmemory_rdata (dmemory_rdata),
      .dmemory_error (dmemory_error),
      .dmemory_ready (dmemory_ready),
      .memory_valid  (memory_valid),
      .memory_instr  (memory_instr),
      .memory_addr   (memory_addr),
      .memory_wdata  (memory_wdata),
      .memory_wstrb  (memory_wstrb),
      .memory_rdata  (memory_rdata),
      .memory_error  (memory_error),
      .memory_ready  (memory_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clock);
      imemory_valid = 1'b0;
      dmemory_valid = 1'b0;
      memory_ready  = 1'b0;
      memory_error  = 1'b0;
   endtask

   task automatic apply_reset();
      next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic wait_issue();
      int n = 0;
      next_cycle();
      #1;
      while (!memory_valid && n < 8) begin
         next_cycle();
         #1;
         n++;
      end
      check("issue_wait", {31'd0, memory_valid}, 32'd1);
   endtask

   task automatic check_idle_ports(input string tag);
      check({tag, "_iready"}, {31'd0, imemory_ready}, 32'd0);
      check({tag, "_dready"}, {31'd0, dmemory_ready}, 32'd0);
   endtask

   initial begin
      // Reset state
      @(negedge clock);
      #1;
      check("rst_mvalid", {31'd0, memory_valid}, 32'd0);
      check("rst_maddr", memory_addr, 32'd0);
      check("rst_minstr", {31'd0, memory_instr}, 32'd0);
      check_idle_ports("rst");
      reset = 1'b1;

      // Single read
      apply_reset();
      dmemory_valid = 1'b1; dmemory_addr = 32'h100; dmemory_wstrb = 4'h0;
      #1 check("rd_c1_mvalid", {31'd0, memory_valid}, 32'd0);
      next_cycle(); #1;
      check("rd_mvalid", {31'd0, memory_valid}, 32'd1);
      check("rd_maddr", memory_addr, 32'h100);
      check("rd_minstr", {31'd0, memory_instr}, 32'd0);
      next_cycle(); #1 check("rd_pulse", {31'd0, memory_valid}, 32'd0);
      next_cycle(); #1 check_idle_ports("rd_c4");
      next_cycle(); memory_ready = 1'b1; memory_rdata = 32'hDEADBEEF;
      #1;
      check("rd_dready", {31'd0, dmemory_ready}, 32'd1);
      check("rd_drdata", dmemory_rdata, 32'hDEADBEEF);
      check("rd_iready", {31'd0, imemory_ready}, 32'd0);
      next_cycle(); #1 check_idle_ports("rd_after");

      // Simultaneous requests: data first after reset
      apply_reset();
      imemory_valid = 1'b1; imemory_addr = 32'h0;
      dmemory_valid = 1'b1; dmemory_addr = 32'h200; dmemory_wdata = 32'h12345678; dmemory_wstrb = 4'hF;
      next_cycle(); #1;
      check("sim_mvalid", {31'd0, memory_valid}, 32'd1);
      check("sim_d_instr", {31'd0, memory_instr}, 32'd0);
      check("sim_d_addr", memory_addr, 32'h200);
      check("sim_d_wdata", memory_wdata, 32'h12345678);
      check("sim_d_wstrb", {28'd0, memory_wstrb}, 32'hF);
      next_cycle();
      next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h1;
      #1 check("sim_dready", {31'd0, dmemory_ready}, 32'd1);
      next_cycle(); #1;
      check("sim_i_mvalid", {31'd0, memory_valid}, 32'd1);
      check("sim_i_instr", {31'd0, memory_instr}, 32'd1);
      check("sim_i_addr", memory_addr, 32'h0);
      check("sim_i_wstrb", {28'd0, memory_wstrb}, 32'h0);
      check("sim_i_wdata", memory_wdata, 32'h0);

      // Fairness: both ports keep requesting
      apply_reset();
      imemory_valid = 1'b1; imemory_addr = 32'h1000;
      dmemory_valid = 1'b1; dmemory_addr = 32'h2000; dmemory_wstrb = 4'h0;
      for (int t = 0; t < 6; t++) begin
         logic [31:0] exp_instr;
         logic        was_instr;
         exp_instr = (t % 2 == 0) ? 32'd0 : 32'd1;
         wait_issue();
         check("fair_grant", {31'd0, memory_instr}, exp_instr);
         was_instr = memory_instr;
         next_cycle();
         memory_ready = 1'b1; memory_rdata = 32'hC0DE_0000 + 32'(t);
         if (was_instr) imemory_valid = 1'b1;
         else dmemory_valid = 1'b1;
         #1;
         if (exp_instr == 32'd1) check("fair_iready", {31'd0, imemory_ready}, 32'd1);
         else check("fair_dready", {31'd0, dmemory_ready}, 32'd1);
      end

      // Watchdog: TIMEOUT=8, never answer
      apply_reset();
      imemory_valid = 1'b1; imemory_addr = 32'h300;
      next_cycle(); #1;
      check("to_mvalid", {31'd0, memory_valid}, 32'd1);
      check("to_minstr", {31'd0, memory_instr}, 32'd1);
      memory_rdata = 32'hA5A5A5A5;
      for (int c = 3; c <= 8; c++) begin
         next_cycle(); #1;
         check("to_early", {31'd0, imemory_ready}, 32'd0);
      end
      next_cycle(); #1;
      check("to_iready", {31'd0, imemory_ready}, 32'd1);
      check("to_ierror", {31'd0, imemory_error}, 32'd1);
      check("to_irdata", imemory_rdata, 32'd0);
      check("to_dready", {31'd0, dmemory_ready}, 32'd0);
      next_cycle(); #1 check("to_once", {31'd0, imemory_ready}, 32'd0);
      next_cycle(); memory_ready = 1'b1;
      #1 check_idle_ports("to_late");
      next_cycle(); #1 check("to_late_mv", {31'd0, memory_valid}, 32'd0);

      // Error passthrough on a data write
      apply_reset();
      dmemory_valid = 1'b1; dmemory_addr = 32'h400; dmemory_wdata = 32'hCAFEF00D; dmemory_wstrb = 4'h3;
      next_cycle(); #1 check("err_wstrb", {28'd0, memory_wstrb}, 32'h3);
      next_cycle(); memory_ready = 1'b1; memory_error = 1'b1; memory_rdata = 32'h0;
      #1;
      check("err_dready", {31'd0, dmemory_ready}, 32'd1);
      check("err_derror", {31'd0, dmemory_error}, 32'd1);
      check("err_iready", {31'd0, imemory_ready}, 32'd0);

      // Reset mid-transaction with an instruction request pending
      apply_reset();
      dmemory_valid = 1'b1; dmemory_addr = 32'h500; dmemory_wstrb = 4'h1;
      next_cycle(); imemory_valid = 1'b1; imemory_addr = 32'h600;
      #1 check("mr_mvalid", {31'd0, memory_valid}, 32'd1);
      next_cycle(); memory_ready = 1'b1; memory_rdata = 32'h77;
      #1 check("mr_pre_dready", {31'd0, dmemory_ready}, 32'd1);
      reset = 1'b0;
      #1;
      check("mr_dready", {31'd0, dmemory_ready}, 32'd0);
      check("mr_drdata", dmemory_rdata, 32'd0);
      check("mr_maddr", memory_addr, 32'd0);
      check("mr_mwstrb", {28'd0, memory_wstrb}, 32'd0);
      check("mr_iready", {31'd0, imemory_ready}, 32'd0);
      next_cycle(); reset = 1'b1;
      next_cycle(); memory_ready = 1'b1;
      #1 check_idle_ports("mr_late");
      for (int c = 0; c < 4; c++) begin
         next_cycle(); #1;
         check("mr_no_issue", {31'd0, memory_valid}, 32'd0);
      end
      imemory_valid = 1'b1; imemory_addr = 32'h700;
      next_cycle(); #1;
      check("mr_new_mv", {31'd0, memory_valid}, 32'd1);
      check("mr_new_addr", memory_addr, 32'h700);
      check("mr_new_instr", {31'd0, memory_instr}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
